// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU select codes, default widths and response-entry layout.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_TAG_W = 4;
    localparam int DEFAULT_DEPTH = 4;

    // Select codes are carried opaquely; the issue unit never decodes them.
    localparam logic [2:0] ALU_SEL_ADD  = 3'b000;
    localparam logic [2:0] ALU_SEL_SUB  = 3'b001;
    localparam logic [2:0] ALU_SEL_AND  = 3'b010;
    localparam logic [2:0] ALU_SEL_OR   = 3'b011;
    localparam logic [2:0] ALU_SEL_XOR  = 3'b100;
    localparam logic [2:0] ALU_SEL_SLT  = 3'b101;
    localparam logic [2:0] ALU_SEL_SHF  = 3'b110;
    localparam logic [2:0] ALU_SEL_PASS = 3'b111;

    // Response entry packs {result, zero, tag} with the tag in the low bits.
    function automatic int rsp_entry_w(input int width, input int tag_w);
        return width + 1 + tag_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Show-ahead synchronous FIFO with occupancy count, async low reset.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_push = push && ((count != FULL_COUNT) || do_pop);

    // Head reads as zero while empty so the response bus is clean after reset.
    assign pop_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_unit
// Brief    : Registers requests onto the ALU and queues tagged results in order.
// Revision : 1.0
// ============================================================================
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TAG_W = DEFAULT_TAG_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [2:0]       req_select,
    input  logic             req_rotate,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [2:0]       alu_select,
    output logic             alu_rotate,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = rsp_entry_w(WIDTH, TAG_W);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic               inflight;
    logic [TAG_W-1:0]   tag_q;
    logic [CW-1:0]      count;
    logic [CW:0]        occupancy;
    logic [ENTRY_W-1:0] head;
    logic               accept;

    // The in-flight op already owns a slot, so the capture push can never overflow.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign req_ready = (occupancy < DEPTH_C);
    assign accept    = req_valid && req_ready;
    assign busy      = inflight || (count != '0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_select <= ALU_SEL_ADD;
            alu_rotate <= 1'b0;
            tag_q      <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                alu_data1  <= req_data1;
                alu_data2  <= req_data2;
                alu_select <= req_select;
                alu_rotate <= req_rotate;
                tag_q      <= req_tag;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (inflight),
        .push_data ({alu_result, alu_zero, tag_q}),
        .pop       (rsp_ready),
        .pop_data  (head),
        .valid     (rsp_valid),
        .count     (count)
    );

    assign {rsp_result, rsp_zero, rsp_tag} = head;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_unit
// Brief    : Table, directed and random checks of alu_issue_unit with a stub adder ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_issue_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_data1 = '0;
    logic [WIDTH-1:0] req_data2 = '0;
    logic [2:0]       req_select = '0;
    logic             req_rotate = 1'b0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [WIDTH-1:0] alu_data1, alu_data2, alu_result;
    logic [2:0]       alu_select;
    logic             alu_rotate, alu_zero;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    always #5 CLK = ~CLK;

    assign alu_result = alu_data1 + alu_data2;
    assign alu_zero   = (alu_result == '0);

    alu_issue_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2),
        .req_select(req_select), .req_rotate(req_rotate), .req_tag(req_tag),
        .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_select(alu_select), .alu_rotate(alu_rotate),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        logic [2:0]       sel;
        logic             rot;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] exp_result;
        logic             exp_zero;
    } vec_t;

    // Reference model: every accepted op waits in q until popped; an op becomes
    // visible to the consumer one edge after its accept.
    exp_t             q[$];
    int               visible = 0;
    int               pending = 0;
    logic [WIDTH-1:0] m_d1 = '0, m_d2 = '0;
    logic [2:0]       m_sel = '0;
    logic             m_rot = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int ready_seen = 0;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        visible = 0;
        pending = 0;
        m_d1 = '0; m_d2 = '0; m_sel = '0; m_rot = 1'b0;
    endtask

    task automatic check_state();
        chk("req_ready", 64'(req_ready), 64'(q.size() < DEPTH));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("rsp_valid", 64'(rsp_valid), 64'(visible > 0));
        if (visible > 0) begin
            chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
            chk("rsp_result", 64'(rsp_result), 64'(q[0].result));
            chk("rsp_zero", 64'(rsp_zero), 64'(q[0].zero));
        end
        chk("alu_data1", 64'(alu_data1), 64'(m_d1));
        chk("alu_data2", 64'(alu_data2), 64'(m_d2));
        chk("alu_select", 64'(alu_select), 64'(m_sel));
        chk("alu_rotate", 64'(alu_rotate), 64'(m_rot));
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                        input logic [2:0] sel, input logic rot, input logic [TAG_W-1:0] tag,
                        input logic rr);
        bit   acc, pop;
        exp_t e;
        @(negedge CLK);
        check_state();
        req_valid = v; req_data1 = d1; req_data2 = d2;
        req_select = sel; req_rotate = rot; req_tag = tag; rsp_ready = rr;
        acc = v && (q.size() < DEPTH);
        pop = rr && (visible > 0);
        if (v && req_ready) ready_seen++;
        @(posedge CLK);
        if (pop) begin
            void'(q.pop_front());
            visible--;
        end
        visible += pending;
        pending = acc ? 1 : 0;
        if (acc) begin
            e.result = d1 + d2;
            e.zero   = ((d1 + d2) == 32'd0);
            e.tag    = tag;
            q.push_back(e);
            m_d1 = d1; m_d2 = d2; m_sel = sel; m_rot = rot;
        end
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, rr);
    endtask

    initial begin
        tbl[0] = '{32'd3,         32'd1,         3'b000, 1'b1, 4'd5,  32'd4,         1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'd1,         3'b000, 1'b0, 4'd2,  32'd0,         1'b1};
        tbl[2] = '{32'd7,         32'hFFFF_FFFF, 3'b101, 1'b0, 4'd1,  32'd6,         1'b0};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 3'b111, 1'b1, 4'd15, 32'd0,         1'b1};

        repeat (2) @(posedge CLK);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_alu_data1", 64'(alu_data1), 64'd0);
        chk("reset_rsp_result", 64'(rsp_result), 64'd0);
        chk("reset_rsp_tag", 64'(rsp_tag), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Table vectors: single op, explicit expected response one edge after accept
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].d1, tbl[i].d2, tbl[i].sel, tbl[i].rot, tbl[i].tag, 1'b0);
            step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
            chk("tbl_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("tbl_rsp_result", 64'(rsp_result), 64'(tbl[i].exp_result));
            chk("tbl_rsp_zero", 64'(rsp_zero), 64'(tbl[i].exp_zero));
            chk("tbl_rsp_tag", 64'(rsp_tag), 64'(tbl[i].tag));
            idle(1, 1'b1);
            idle(1, 1'b0);
            chk("tbl_busy_after_pop", 64'(busy), 64'd0);
        end

        // Backpressure: only DEPTH of six back-to-back requests get in
        ready_seen = 0;
        for (int t = 0; t < 6; t++)
            step(1'b1, $urandom, $urandom, 3'($urandom), 1'($urandom), 4'(t), 1'b0);
        chk("bp_accepts", 64'(ready_seen), 64'(DEPTH));
        idle(2, 1'b0);
        idle(6, 1'b1);

        // Streaming with the consumer always ready: no stalls, pointers wrap
        ready_seen = 0;
        for (int t = 0; t < 16; t++)
            step(1'b1, $urandom, $urandom, 3'($urandom), 1'($urandom), 4'(t), 1'b1);
        chk("stream_accepts", 64'(ready_seen), 64'd16);
        idle(3, 1'b1);

        // Near-full with consumer toggling every cycle
        for (int t = 0; t < 3; t++)
            step(1'b1, $urandom, $urandom, 3'($urandom), 1'($urandom), 4'(t), 1'b0);
        for (int t = 0; t < 20; t++)
            step(1'b1, $urandom, $urandom, 3'($urandom), 1'($urandom), 4'(t + 3), 1'(t % 2));
        idle(8, 1'b1);

        // Reset with three queued and one in flight
        for (int t = 0; t < 4; t++)
            step(1'b1, $urandom, $urandom, 3'($urandom), 1'b1, 4'(t + 4), 1'b0);
        #2 RESET = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_alu_data1", 64'(alu_data1), 64'd0);
        chk("midrst_alu_select", 64'(alu_select), 64'd0);
        chk("midrst_alu_rotate", 64'(alu_rotate), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        step(1'b1, 32'd10, 32'd20, 3'b010, 1'b0, 4'd9, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
        chk("post_rst_tag", 64'(rsp_tag), 64'd9);
        chk("post_rst_result", 64'(rsp_result), 64'd30);
        idle(2, 1'b1);

        // Random traffic against the reference model
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0) ? -$urandom_range(0, 3) : $urandom,
                 3'($urandom), 1'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
Initiator-side front end for the 32-bit integer ALU. It accepts operation requests (data1, data2, select, rotate, tag) over a valid/ready channel and drives the ALU operand/control inputs from registers. It samples the combinational ALU outputs (result, zero) one cycle later and returns them with the matching tag through a response FIFO with valid/ready backpressure. It sits between execute-stage control (or a bring-up sequencer) and the ALU, so the ALU can be exercised and back-pressured without a testbench driving it.

Parameters:
WIDTH, 32, operand/result width
TAG_W, 4, request tag width; the tag is returned unchanged with the response
DEPTH, 4, response FIFO entries; must be a power of two and >= 2

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous reset, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_data1  in  WIDTH  operand 1
req_data2  in  WIDTH  operand 2
req_select  in  3  ALU select code, passed through opaquely
req_rotate  in  1  ALU rotate/shift-mode bit
req_tag  in  TAG_W  request identifier
alu_data1  out  WIDTH  registered operand 1 to ALU
alu_data2  out  WIDTH  registered operand 2 to ALU
alu_select  out  3  registered select to ALU
alu_rotate  out  1  registered rotate to ALU
alu_result  in  WIDTH  ALU result (combinational from alu_* outputs)
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response FIFO non-empty
rsp_ready  in  1  consumer takes the head response
rsp_result  out  WIDTH  head result
rsp_zero  out  1  head zero flag
rsp_tag  out  TAG_W  head tag
busy  out  1  op in flight or FIFO non-empty

Behaviour:
- Reset (RESET=0, async): alu_data1/alu_data2 = 0, alu_select = 3'b000, alu_rotate = 0. The in-flight flag, FIFO pointers and occupancy clear. rsp_valid = 0; rsp_result/rsp_zero/rsp_tag = 0. busy = 0. A reset mid-operation discards all in-flight and queued ops; no partial responses.
- Accept: a handshake occurs when req_valid && req_ready at a rising edge N.
  - At edge N, alu_* registers load the request fields, inflight <= 1, and the tag is stored in tag_q.
  - With no new accept, alu_* outputs hold their last values; inflight <= 0.
- Capture: at edge N+1, if inflight = 1, {alu_result, alu_zero, tag_q} is pushed into the FIFO. rsp_valid is high after edge N+1 (one-cycle latency from the accept edge).
- Back-to-back: one accept per cycle is sustainable while space allows; each captured op corresponds to the previous edge's accept.
- Credit rule: req_ready = (count + inflight) < DEPTH, computed combinationally from registers only, with no dependence on req_valid or rsp_ready. This guarantees a push never hits a full FIFO.
- Pop: on rsp_valid && rsp_ready at an edge, the head is removed.
  - rsp_* are driven from FIFO head storage (show-ahead).
  - rsp_* hold their values while rsp_valid = 1 and rsp_ready = 0.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance. A pop from a count=1 FIFO concurrent with a push yields rsp_valid staying 1 with the new entry.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Responses return strictly in request order.
- busy = inflight || (count != 0).
- No arithmetic on operands; select/rotate are not decoded.

Decomposition:
- alu_pkg: ALU select code constants (3-bit), default WIDTH, and the response-entry field layout {result, zero, tag}.
- One sub-module: sync_fifo (parameterised WIDTH/DEPTH, show-ahead, count output, same CLK/RESET convention), instantiated for the response queue with data width WIDTH+1+TAG_W.

Test Plan (bench drives a stub ALU: result = data1+data2, zero = (result==0)):
- Reset then a single request data1=3, data2=1, select=000, rotate=1, tag=5, rsp_ready=1 -> alu_data1=3 after the accept edge; rsp_valid=1 one edge later with rsp_result=4, rsp_zero=0, rsp_tag=5; busy returns to 0 after the pop.
- Zero flag: data1=32'hFFFFFFFF, data2=1, tag=2 -> rsp_result=0, rsp_zero=1, rsp_tag=2.
- Backpressure: rsp_ready=0, issue 6 back-to-back requests with tags 0..5 -> exactly DEPTH=4 accepted and req_ready=0 thereafter; head stays tag 0 and stable. Raise rsp_ready -> tags 0,1,2,3 drain in order, then req_ready reasserts.
- Streaming: rsp_ready=1, 16 consecutive requests with tags 0..15 and random operands -> one response per cycle, in order, all sums correct, no stall cycles, pointer wrap exercised.
- Simultaneous push/pop at count=DEPTH-1 with rsp_ready toggling every cycle -> no overflow, no lost or duplicated tags, and count never exceeds 4.
- Reset asserted with 3 queued responses and 1 in flight -> immediately rsp_valid=0, busy=0, alu_* = 0. After release, a fresh request with tag 9 returns tag 9 as the first response.
